mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares a 4-input, `g_WIDTH`-bit datapath mux between four requesters in the pipelined CPU. Typical sharers are writeback sources or a shared memory port. The block selects a winner and drives the select code for the shared 4:1 mux. It captures the winner's data into an output register and presents it downstream on a valid/ready handshake. Fairness comes from a rotating priority pointer; an optional lock lets one requester hold the resource across multiple beats.

## Interface
Parameters:
- `g_WIDTH`, default 8: data width of each source and of `o_Data`.

Ports:
- `i_Clk` input 1: clock, rising edge.
- `i_Rst_n` input 1: reset, asynchronous, active-low.
- `i_Req` input 4: request per source; bit k corresponds to `i_Data(k+1)`.
- `i_Lock` input 4: per-source lock request; used only with `MUX_ARB_LOCK_EN`, otherwise ignored.
- `i_Data1`..`i_Data4` input `g_WIDTH`: source data.
- `o_Grant` output 4: one-hot capture acknowledge, combinational, active in the capture cycle.
- `o_Select` output 2: registered select of the last captured source.
- `o_Data` output `g_WIDTH`: registered captured data.
- `o_Valid` output 1: `o_Data` valid downstream.
- `i_Ready` input 1: downstream accepts `o_Data` when high together with `o_Valid`.

## Operation
States:
- IDLE: `o_Valid`=0.
- SEND: `o_Valid`=1.

Arbitration window:
- The window is open in IDLE, and in SEND in a cycle where `i_Ready`=1 (handshake cycle).

In an open window with any eligible `i_Req` bit:
- Winner = first set bit scanning from `ptr`, ptr, ptr+1, ... mod 4.
- `o_Grant`[winner]=1 for that cycle only.
- At the next edge: `o_Data` <= winner's data, `o_Select` <= winner, `ptr` <= winner+1 (mod 4, 2-bit wrap), state <= SEND.
- Requester contract: hold req and data stable until it sees its `o_Grant` bit. The cycle with the grant bit high is the capture cycle. Deassert or present new data after it.

Transitions:
- Open window with no eligible request: state <= IDLE. The handshake, if any, still completes.
- SEND with `i_Ready`=0: `o_Data`, `o_Select` and `o_Valid` hold, `o_Grant`=0, `ptr` holds.
- Back-to-back: a handshake and a new capture in the same cycle give continuous `o_Valid`=1 with one beat per cycle.

Reset and gating:
- `o_Grant` is forced to 0 while `i_Rst_n`=0.
- Reset values: `o_Valid`=0, `o_Data`=0, `o_Select`=0, `o_Grant`=0, `ptr`=0, state IDLE, lock owner cleared.
- Reset asserted mid-transfer drops the pending beat immediately (asynchronous); no partial handshake is reported.

## Timing
- Request to grant: 0 cycles when the window is open (`o_Grant` is combinational from `i_Req`, state, `i_Ready`, `ptr`).
- Capture to `o_Valid`: 1 cycle. Request at cycle N in IDLE gives `o_Valid`=1 from cycle N+1.
- Throughput: 1 beat per cycle with `i_Ready` held high and requests present.
- Starvation bound: a requester holding `i_Req` is granted within 4 windows. This bound applies without lock.

## Configuration
Macro `MUX_ARB_LOCK_EN`.

Defined:
- At capture, if `i_Lock`[winner]=1, the winner becomes lock owner.
- While an owner exists, only the owner is eligible; other requests are masked and `ptr` is not advanced.
- If the owner's `i_Req`=0 while locked, no grant occurs and the resource stays parked for the owner.
- The lock is released at the first capture of the owner with `i_Lock`[owner]=0. That capture advances `ptr` normally.

Undefined:
- `i_Lock` has no effect.
- No owner register is built.
- Behaviour is pure round-robin.

## Test plan
- Reset with `i_Req`=4'b1111 held -> `o_Grant`=0, `o_Valid`=0, `o_Data`=0 during reset. After release, first grant is 4'b0001.
- Single `i_Req`=4'b0100, `i_Data3`=8'hA5, `i_Ready`=1 -> `o_Grant`=4'b0100 for one cycle. Next cycle `o_Valid`=1, `o_Data`=8'hA5, `o_Select`=2'b10.
- `i_Req`=4'b1111 continuous, `i_Ready`=1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, `o_Valid` continuously 1.
- Capture `i_Data2`=8'h3C, then `i_Ready`=0 for 3 cycles -> `o_Data`=8'h3C, `o_Valid`=1 and `o_Grant`=0 held. Handshake happens on the 4th cycle.
- With `MUX_ARB_LOCK_EN`: source 1 wins with `i_Lock`[1]=1 while `i_Req`=4'b1111 -> source 1 granted every window until a capture with `i_Lock`[1]=0. The next grant is 4'b0100.
- `i_Rst_n` pulsed low while in SEND with `i_Ready`=0 -> `o_Valid` drops asynchronously. After release, arbitration restarts from `ptr`=0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux with a registered valid/ready output stage.
// Optional ownership lock is enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int g_WIDTH = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [3:0]         i_Req,
  input  logic [3:0]         i_Lock,
  input  logic [g_WIDTH-1:0] i_Data1,
  input  logic [g_WIDTH-1:0] i_Data2,
  input  logic [g_WIDTH-1:0] i_Data3,
  input  logic [g_WIDTH-1:0] i_Data4,
  output logic [3:0]         o_Grant,
  output logic [1:0]         o_Select,
  output logic [g_WIDTH-1:0] o_Data,
  output logic               o_Valid,
  input  logic               i_Ready
);

  // state | meaning
  // IDLE  | output register empty, window always open
  // SEND  | o_Data valid, window opens only on handshake
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [g_WIDTH-1:0] data_q, data_d;

  logic               window;
  logic [3:0]         elig;
  logic               any_elig;
  logic               capture;
  logic [1:0]         winner;
  logic [1:0]         scan_idx;
  logic               found;
  logic [g_WIDTH-1:0] mux_data;

`ifdef MUX_ARB_LOCK_EN
  logic       lock_vld_q, lock_vld_d;
  logic [1:0] owner_q, owner_d;

  // A held lock masks every requester except the owner.
  assign elig = lock_vld_q ? (i_Req & (4'b0001 << owner_q)) : i_Req;
`else
  logic unused_lock;

  assign unused_lock = ^i_Lock;
  assign elig        = i_Req;
`endif

  assign window   = (state_q == IDLE) || i_Ready;
  assign any_elig = |elig;
  assign capture  = window && any_elig && i_Rst_n;
  assign o_Grant  = capture ? (4'b0001 << winner) : 4'b0000;
  assign o_Valid  = (state_q == SEND);
  assign o_Select = sel_q;
  assign o_Data   = data_q;

  always_comb begin
    winner   = ptr_q;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && elig[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    mux_data = i_Data1;
      2'd1:    mux_data = i_Data2;
      2'd2:    mux_data = i_Data3;
      default: mux_data = i_Data4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (window) begin
      if (any_elig) begin
        state_d = SEND;
        sel_d   = winner;
        data_d  = mux_data;
        ptr_d   = winner + 2'd1;
      end else begin
        state_d = IDLE;
      end
    end
`ifdef MUX_ARB_LOCK_EN
    lock_vld_d = lock_vld_q;
    owner_d    = owner_q;
    if (window && any_elig) begin
      if (lock_vld_q) begin
        if (!i_Lock[owner_q]) lock_vld_d = 1'b0;
        else                  ptr_d      = ptr_q;
      end else if (i_Lock[winner]) begin
        lock_vld_d = 1'b1;
        owner_d    = winner;
      end
    end
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      lock_vld_q <= 1'b0;
      owner_q    <= 2'd0;
    end else begin
      lock_vld_q <= lock_vld_d;
      owner_q    <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a capture scoreboard of {select, data}.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] lock = 4'b0000;
  logic [7:0] d1 = 8'h11, d2 = 8'h22, d3 = 8'h33, d4 = 8'h44;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.g_WIDTH(8)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Req   (req),
    .i_Lock  (lock),
    .i_Data1 (d1),
    .i_Data2 (d2),
    .i_Data3 (d3),
    .i_Data4 (d4),
    .o_Grant (grant),
    .o_Select(sel),
    .o_Data  (data),
    .o_Valid (valid),
    .i_Ready (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] src_data(input int k);
    return 8'(8'h11 * (k + 1));
  endfunction

  task automatic sb_push(input logic [1:0] s, input logic [7:0] d);
    sb.push_back({s, d});
  endtask

  task automatic sb_pop(input string tag);
    logic [9:0] e;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(data), 32'(e[7:0]));
      chk({tag, "_sel"}, 32'(sel), 32'(e[9:8]));
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // reset with all requests held
    req = 4'b1111;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(grant), 32'h1);
    sb_push(2'd0, d1);
    step();
    sb_pop("first_cap");
    req = 4'b0000;
    ready = 1'b1;
    #1;
    chk("noreq_grant", 32'(grant), 32'h0);
    step();
    chk("first_drain", 32'(valid), 32'h0);

    // single requester
    req = 4'b0100;
    d3 = 8'hA5;
    #1;
    chk("single_grant", 32'(grant), 32'h4);
    sb_push(2'd2, 8'hA5);
    step();
    req = 4'b0000;
    d3 = 8'h33;
    sb_pop("single_cap");
    #1;
    chk("single_grant_off", 32'(grant), 32'h0);
    step();
    chk("single_drain", 32'(valid), 32'h0);

    // continuous round robin from ptr 0
    rst_pulse();
    req = 4'b1111;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      sb_push(2'(k % 4), src_data(k % 4));
      step();
      sb_pop("rr_cap");
    end
    req = 4'b0000;
    step();
    chk("rr_drain", 32'(valid), 32'h0);

    // backpressure hold (ptr is 1)
    req = 4'b0010;
    d2 = 8'h3C;
    #1;
    chk("hold_grant", 32'(grant), 32'h2);
    sb_push(2'd1, 8'h3C);
    step();
    sb_pop("hold_cap");
    req = 4'b1111;
    ready = 1'b0;
    d2 = 8'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_grant0", 32'(grant), 32'h0);
      chk("hold_valid", 32'(valid), 32'h1);
      chk("hold_data", 32'(data), 32'h3C);
      chk("hold_sel", 32'(sel), 32'h1);
      step();
    end
    ready = 1'b1;
    #1;
    chk("hold_release_grant", 32'(grant), 32'h4);
    sb_push(2'd2, d3);
    step();
    sb_pop("hold_next_cap");
    req = 4'b0000;
    step();
    chk("hold_drain", 32'(valid), 32'h0);

    // async reset mid-transfer (ptr is 3)
    req = 4'b1000;
    #1;
    chk("arst_grant", 32'(grant), 32'h8);
    sb_push(2'd3, d4);
    step();
    sb_pop("arst_cap");
    ready = 1'b0;
    req = 4'b1111;
    #1;
    chk("arst_bp_grant", 32'(grant), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_grant_rst", 32'(grant), 32'h0);
    chk("arst_data", 32'(data), 32'h0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    chk("arst_restart_grant", 32'(grant), 32'h1);
    sb_push(2'd0, d1);
    step();
    sb_pop("arst_restart_cap");
    req = 4'b0000;
    step();
    chk("arst_drain", 32'(valid), 32'h0);

`ifdef MUX_ARB_LOCK_EN
    rst_pulse();
    req = 4'b1111;
    lock = 4'b0010;
    ready = 1'b1;
    #1;
    chk("lk_g0", 32'(grant), 32'h1);
    sb_push(2'd0, d1);
    step();
    sb_pop("lk_c0");
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lk_owner_grant", 32'(grant), 32'h2);
      sb_push(2'd1, d2);
      step();
      sb_pop("lk_owner_cap");
    end
    req = 4'b1101;
    #1;
    chk("lk_parked_grant", 32'(grant), 32'h0);
    step();
    chk("lk_parked_valid", 32'(valid), 32'h0);
    req = 4'b1111;
    lock = 4'b0000;
    #1;
    chk("lk_release_grant", 32'(grant), 32'h2);
    sb_push(2'd1, d2);
    step();
    sb_pop("lk_release_cap");
    #1;
    chk("lk_after_grant", 32'(grant), 32'h4);
    sb_push(2'd2, d3);
    step();
    sb_pop("lk_after_cap");
    req = 4'b0000;
    step();
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
